mem_sram_ctrl: RTL and testbench
================================

Name: mem_sram_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register in the MIPS/ARM-style core.
- Takes the memory-stage controls MEM_R_EN / MEM_W_EN, ALU_result (byte address) and ST_val (store data).
- Performs each 32-bit load/store as two 16-bit accesses on an external asynchronous SRAM.
- Holds `ready` low while the access is in progress; the hazard/freeze logic uses it to stall every pipeline register.

Parameters:
- ADDR_BASE, 1024, byte address mapped to SRAM half-word 0.
- SRAM_AW, 18, SRAM address width.
- WAIT_CYCLES, 2, clock cycles each 16-bit phase is held; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- MEM_R_EN  in  1  load request, from EX/MEM register.
- MEM_W_EN  in  1  store request, from EX/MEM register.
- address  in  32  byte address (ALU_result).
- wdata  in  32  store data (ST_val).
- rdata  out  32  load data.
- ready  out  1  0 = freeze pipeline.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the bus.
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, rdata=0.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- Reset mid-access: the same reset values apply immediately. The SRAM write is abandoned and may be partial. No recovery is attempted.
- Address map:
  - word = (address - ADDR_BASE) >> 2, truncated to SRAM_AW-1 bits.
  - Low phase: sram_addr = {word, 1'b0}. High phase: sram_addr = {word, 1'b1}.
  - address[1:0] is ignored. No range check.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - If MEM_W_EN or MEM_R_EN is high, capture the access type, address and wdata into internal registers, go to LO, and load counter=WAIT_CYCLES-1.
  - If both enables are high, the access is a write.
  - Otherwise stay in IDLE.
- LO:
  - Drive sram_addr and sram_dq_out=wdata[15:0] from the captured registers.
  - Write: sram_we_n=0 and sram_dq_oe=1 for the entire phase.
  - Counter decrements each cycle. When counter==0, go to HI and reload counter=WAIT_CYCLES-1.
  - Read: on the counter==0 cycle, capture sram_dq_in into rdata[15:0].
- HI:
  - Same as LO, using wdata[31:16] and rdata[31:16].
  - When counter==0, go to DONE.
- DONE:
  - sram_we_n=1, sram_dq_oe=0.
  - Unconditionally go to IDLE on the next edge; no new request is accepted in DONE.
  - The pipeline advances on that same edge, so the request still present in DONE is not re-executed.
- ready (combinational):
  - ready = (IDLE && !MEM_R_EN && !MEM_W_EN) || DONE.
  - A request in IDLE drops ready in the same cycle.
- Timing:
  - Each access occupies 2*WAIT_CYCLES+1 cycles from request to the DONE cycle inclusive.
  - ready is low for 2*WAIT_CYCLES cycles; WAIT_CYCLES=2 gives 4 low cycles and ready high in the 5th.
  - Back-to-back accesses give one IDLE-request cycle, then the next access.
- rdata:
  - Valid in DONE of a read.
  - Holds its value until the next read's LO capture; writes never change it.
- While busy, the address, MEM_R_EN/MEM_W_EN and wdata inputs are ignored; the captured copies are used.
- sram_we_n is never 0 outside LO/HI of a write.
- sram_dq_oe == !sram_we_n at all times.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit: IDLE=0, LO=1, HI=2, DONE=3).
  - ADDR_BASE default.
  - SRAM data width constant 16.
- No sub-module is required. Use the existing parameterised `register` block for the captured address/wdata/type only if it supports an async active-low clear; otherwise use local flops.

Test Plan:
- Reset: rst=0 during an active write in LO -> sram_we_n=1, sram_dq_oe=0, rdata=0 and ready=1 in the same cycle with enables low. After rst=1, the first request starts from IDLE.
- Store: MEM_W_EN=1, address=1032, wdata=32'hDEADBEEF, WAIT_CYCLES=2:
  - ready low for 4 cycles.
  - sram_addr=4 with dq_out=16'hBEEF, we_n=0 for 2 cycles.
  - Then sram_addr=5 with dq_out=16'hDEAD for 2 cycles.
  - ready=1 in cycle 5.
- Load: preload SRAM model half-word 4=16'h1234 and 5=16'h5678, MEM_R_EN=1, address=1032 -> rdata=32'h56781234 in DONE, sram_we_n stays 1 throughout, rdata is held afterwards.
- Back-to-back: store then load to the same address with the pipeline frozen by ready -> load returns the stored word. The store executes exactly once (count we_n phases = 2).
- Both enables high, address=1024, wdata=32'h0000CAFE -> treated as write; SRAM half-words 0/1 = CAFE/0000; rdata unchanged.
- Latency sweep: WAIT_CYCLES=1 and 15 -> ready low for exactly 2 and 30 cycles respectively; no we_n glitch between the LO and HI phases except the address change.

Source files
------------

// File: rtl/mem_sram_ctrl_pkg.sv
// Shared constants for the memory-stage SRAM controller: FSM encoding and bus sizes.
package mem_sram_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int unsigned ADDR_BASE_DEF = 1024;
  localparam int unsigned SRAM_DW       = 16;

endpackage

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: each 32-bit load/store becomes two 16-bit async SRAM accesses.
// Latency: 2*WAIT_CYCLES cycles after the request is accepted, plus one DONE cycle with ready high.
// Backpressure: ready drops combinationally on a request in IDLE and stays low until DONE.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]         state;
  logic [3:0]         cnt;
  logic               is_wr;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic [31:0]        offset;
  logic               req;
  logic               in_phase;
  logic               unused_offset_bits;

  assign req    = MEM_R_EN | MEM_W_EN;
  assign offset = address - 32'(ADDR_BASE);
  // Byte lane bits and anything above the SRAM word range are dropped: no range check.
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      rdata   <= 32'd0;
      is_wr   <= 1'b0;
      word_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            is_wr   <= MEM_W_EN;
            word_q  <= offset[SRAM_AW:2];
            wdata_q <= wdata;
            cnt     <= CNT_LOAD;
            state   <= ST_LO;
          end
        end
        ST_LO: begin
          if (cnt == 4'd0) begin
            if (!is_wr) rdata[15:0] <= sram_dq_in;
            cnt   <= CNT_LOAD;
            state <= ST_HI;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HI: begin
          if (cnt == 4'd0) begin
            if (!is_wr) rdata[31:16] <= sram_dq_in;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        // The pipeline advances on this edge, so the stale request is not re-accepted.
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_phase = (state == ST_LO) || (state == ST_HI);

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    if (in_phase) sram_addr = {word_q, state == ST_HI};
    if (state == ST_LO) sram_dq_out = wdata_q[15:0];
    if (state == ST_HI) sram_dq_out = wdata_q[31:16];
  end

  // Strobe and bus drive come from the same term so they can never disagree.
  assign sram_dq_oe = in_phase & is_wr;
  assign sram_we_n  = ~sram_dq_oe;
  assign ready      = ((state == ST_IDLE) && !req) || (state == ST_DONE);

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl with a behavioural SRAM and two extra latency instances.
module tb_mem_sram_ctrl;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] dat;
    int          len;
  } wr_ph_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        a_r, a_w, b_r, b_w;
  logic [31:0] lat_addr, lat_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ready, b_ready, a_oe, b_oe, a_we_n, b_we_n;
  logic [17:0] a_saddr, b_saddr;
  logic [15:0] a_dq, b_dq;

  int n_vec = 0;
  int n_err = 0;
  int oe_bad = 0;

  wr_ph_t      obs_wr_q[$];
  wr_ph_t      exp_wr_q[$];
  logic [31:0] exp_rd_q[$];

  logic [15:0] sram_mem [0:255];
  logic        pre_vld = 1'b0;
  logic [7:0]  pre_addr;
  logic [15:0] pre_dat;
  logic        prev_we_n = 1'b1;
  logic [17:0] prev_addr = '0;

  always #5 clk = ~clk;

  mem_sram_ctrl #(.ADDR_BASE(1024), .SRAM_AW(18), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst_n), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  mem_sram_ctrl #(.ADDR_BASE(1024), .SRAM_AW(18), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst_n), .MEM_R_EN(a_r), .MEM_W_EN(a_w),
    .address(lat_addr), .wdata(lat_wdata), .rdata(a_rdata), .ready(a_ready),
    .sram_addr(a_saddr), .sram_dq_out(a_dq), .sram_dq_in(16'h0000),
    .sram_dq_oe(a_oe), .sram_we_n(a_we_n)
  );

  mem_sram_ctrl #(.ADDR_BASE(1024), .SRAM_AW(18), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst(rst_n), .MEM_R_EN(b_r), .MEM_W_EN(b_w),
    .address(lat_addr), .wdata(lat_wdata), .rdata(b_rdata), .ready(b_ready),
    .sram_addr(b_saddr), .sram_dq_out(b_dq), .sram_dq_in(16'h0000),
    .sram_dq_oe(b_oe), .sram_we_n(b_we_n)
  );

  // Asynchronous SRAM model: combinational read, write while we_n is low.
  assign sram_dq_in = sram_mem[sram_addr[7:0]];
  always @(posedge clk) begin
    if (sram_we_n === 1'b0) sram_mem[sram_addr[7:0]] <= sram_dq_out;
    else if (pre_vld) sram_mem[pre_addr] <= pre_dat;
  end

  // Each write phase is one entry: a fresh strobe or an address change starts a new one.
  always @(negedge clk) begin
    if (sram_dq_oe === sram_we_n) oe_bad <= oe_bad + 1;
    if (sram_we_n === 1'b0) begin
      if (prev_we_n || sram_addr != prev_addr || obs_wr_q.size() == 0)
        obs_wr_q.push_back('{sram_addr, sram_dq_out, 1});
      else
        obs_wr_q[obs_wr_q.size()-1].len = obs_wr_q[obs_wr_q.size()-1].len + 1;
    end
    prev_we_n <= sram_we_n;
    prev_addr <= sram_addr;
  end

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_dat  = d;
    pre_vld  = 1'b1;
    @(posedge clk); #1;
    pre_vld  = 1'b0;
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
    end
  endtask

  // Holds the request like a frozen pipeline; returns at the negedge of the DONE cycle.
  task automatic run_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic req_rdy, output int low, output int we_low,
                            output logic [31:0] rd, output logic done_we_n, output bit tmo);
    mem_r_en = r; mem_w_en = w; address = a; wdata = d;
    @(negedge clk);
    req_rdy = ready;
    low = 0; we_low = 0; tmo = 1'b1; rd = 'x; done_we_n = 1'bx;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); @(negedge clk);
      if (ready === 1'b1) begin
        tmo = 1'b0; rd = rdata; done_we_n = sram_we_n;
        break;
      end
      low++;
      if (sram_we_n === 1'b0) we_low++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; wdata = '0;
    a_r = 0; a_w = 0; b_r = 0; b_w = 0; lat_addr = '0; lat_wdata = '0;
    #1 rst_n = 1'b0;
    #2;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready); end
    n_vec++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n); end
    n_vec++; if (sram_dq_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe got=%b exp=0", sram_dq_oe); end
    n_vec++; if (sram_addr !== 18'd0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
    n_vec++; if (sram_dq_out !== 16'd0) begin n_err++; $display("FAIL reset_dq got=%h exp=0", sram_dq_out); end
    n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    logic rq, dwe; int lo, we; logic [31:0] rd; bit tmo; wr_ph_t e, o; int oe0;
    obs_wr_q.delete();
    exp_wr_q.push_back('{18'd4, 16'hBEEF, 2});
    exp_wr_q.push_back('{18'd5, 16'hDEAD, 2});
    oe0 = oe_bad;
    run_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, rq, lo, we, rd, dwe, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL store_timeout ready never returned"); end
    n_vec++; if (rq !== 1'b0) begin n_err++; $display("FAIL store_req_ready got=%b exp=0", rq); end
    n_vec++; if (lo != 4) begin n_err++; $display("FAIL store_low_cycles got=%0d exp=4", lo); end
    n_vec++; if (we != 4) begin n_err++; $display("FAIL store_we_cycles got=%0d exp=4", we); end
    n_vec++; if (dwe !== 1'b1) begin n_err++; $display("FAIL store_done_we_n got=%b exp=1", dwe); end
    n_vec++; if (obs_wr_q.size() != exp_wr_q.size()) begin
      n_err++; $display("FAIL store_phases got=%0d exp=%0d", obs_wr_q.size(), exp_wr_q.size()); end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
      n_vec++; if (o.addr !== e.addr || o.dat !== e.dat || o.len != e.len) begin
        n_err++; $display("FAIL store_phase got=%h/%h/%0d exp=%h/%h/%0d", o.addr, o.dat, o.len, e.addr, e.dat, e.len); end
    end
    exp_wr_q.delete();
    go_idle(2);
    n_vec++; if (oe_bad != oe0) begin n_err++; $display("FAIL store_oe_vs_we got=%0d bad cycles exp=0", oe_bad - oe0); end
  endtask

  task automatic test_load();
    logic rq, dwe; int lo, we; logic [31:0] rd, e; bit tmo;
    preload(8'd4, 16'h1234);
    preload(8'd5, 16'h5678);
    obs_wr_q.delete();
    exp_rd_q.push_back(32'h56781234);
    run_access(1'b1, 1'b0, 32'd1032, 32'hFFFF_FFFF, rq, lo, we, rd, dwe, tmo);
    e = exp_rd_q.pop_front();
    n_vec++; if (tmo) begin n_err++; $display("FAIL load_timeout ready never returned"); end
    n_vec++; if (rd !== e) begin n_err++; $display("FAIL load_rdata got=%h exp=%h", rd, e); end
    n_vec++; if (lo != 4) begin n_err++; $display("FAIL load_low_cycles got=%0d exp=4", lo); end
    n_vec++; if (we != 0 || obs_wr_q.size() != 0) begin
      n_err++; $display("FAIL load_we_n got=%0d low cycles exp=0", we); end
    go_idle(1);
    preload(8'd4, 16'hFFFF);
    go_idle(3);
    n_vec++; if (rdata !== 32'h56781234) begin n_err++; $display("FAIL load_hold got=%h exp=56781234", rdata); end
  endtask

  task automatic test_back_to_back();
    logic rq, dwe; int lo, we; logic [31:0] rd, e; bit tmo;
    obs_wr_q.delete();
    run_access(1'b0, 1'b1, 32'd1032, 32'hA1B2C3D4, rq, lo, we, rd, dwe, tmo);
    n_vec++; if (tmo || lo != 4) begin n_err++; $display("FAIL b2b_store_low got=%0d exp=4", lo); end
    @(posedge clk); #1;
    exp_rd_q.push_back(32'hA1B2C3D4);
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, rq, lo, we, rd, dwe, tmo);
    e = exp_rd_q.pop_front();
    n_vec++; if (rq !== 1'b0) begin n_err++; $display("FAIL b2b_load_req_ready got=%b exp=0", rq); end
    n_vec++; if (tmo || lo != 4) begin n_err++; $display("FAIL b2b_load_low got=%0d exp=4", lo); end
    n_vec++; if (rd !== e) begin n_err++; $display("FAIL b2b_rdata got=%h exp=%h", rd, e); end
    n_vec++; if (obs_wr_q.size() != 2) begin n_err++; $display("FAIL b2b_store_phases got=%0d exp=2", obs_wr_q.size()); end
    go_idle(2);
  endtask

  task automatic test_both_en();
    logic rq, dwe; int lo, we; logic [31:0] rd; bit tmo;
    preload(8'd0, 16'h1111);
    preload(8'd1, 16'h2222);
    obs_wr_q.delete();
    run_access(1'b1, 1'b1, 32'd1024, 32'h0000CAFE, rq, lo, we, rd, dwe, tmo);
    n_vec++; if (tmo || we != 4) begin n_err++; $display("FAIL both_we_cycles got=%0d exp=4", we); end
    n_vec++; if (rd !== 32'hA1B2C3D4) begin n_err++; $display("FAIL both_rdata got=%h exp=a1b2c3d4", rd); end
    go_idle(1);
    n_vec++; if (sram_mem[0] !== 16'hCAFE) begin n_err++; $display("FAIL both_mem0 got=%h exp=cafe", sram_mem[0]); end
    n_vec++; if (sram_mem[1] !== 16'h0000) begin n_err++; $display("FAIL both_mem1 got=%h exp=0000", sram_mem[1]); end
  endtask

  task automatic test_reset_mid();
    logic rq, dwe; int lo, we; logic [31:0] rd; bit tmo;
    mem_w_en = 1'b1; address = 32'd1040; wdata = 32'h12345678;
    @(posedge clk); #1;
    n_vec++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL rstmid_in_lo got=%b exp=0", sram_we_n); end
    rst_n = 1'b0; mem_w_en = 1'b0;
    #1;
    n_vec++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      n_err++; $display("FAIL rstmid_strobe got=%b/%b exp=1/0", sram_we_n, sram_dq_oe); end
    n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL rstmid_rdata got=%h exp=0", rdata); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
    n_vec++; if (sram_addr !== 18'd0) begin n_err++; $display("FAIL rstmid_addr got=%h exp=0", sram_addr); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    obs_wr_q.delete();
    run_access(1'b0, 1'b1, 32'd1048, 32'h0BADF00D, rq, lo, we, rd, dwe, tmo);
    n_vec++; if (tmo || lo != 4) begin n_err++; $display("FAIL rstmid_restart_low got=%0d exp=4", lo); end
    n_vec++; if (obs_wr_q.size() != 2 || obs_wr_q[0].addr !== 18'd12 || obs_wr_q[0].dat !== 16'hF00D
                 || obs_wr_q[1].addr !== 18'd13 || obs_wr_q[1].dat !== 16'h0BAD) begin
      n_err++; $display("FAIL rstmid_restart_phases got=%0d phases exp=2 at 00c/f00d,00d/0bad", obs_wr_q.size()); end
    go_idle(2);
  endtask

  task automatic test_latency();
    int lo1 = 0, we1 = 0, ch1 = 0, lo15 = 0, we15 = 0, ch15 = 0;
    bit d1 = 0, d15 = 0;
    logic [17:0] p1 = '0, p15 = '0;
    bit s1 = 0, s15 = 0;
    lat_addr = 32'd1028; lat_wdata = 32'h5A5A_A5A5;
    a_w = 1'b1; b_w = 1'b1;
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_err++; $display("FAIL lat_req_ready got=%b/%b exp=0/0", a_ready, b_ready); end
    for (int i = 0; i < 80 && !(d1 && d15); i++) begin
      @(posedge clk); #1;
      if (d1) a_w = 1'b0;
      if (d15) b_w = 1'b0;
      @(negedge clk);
      if (!d1) begin
        if (a_ready === 1'b1) d1 = 1;
        else begin
          lo1++;
          if (a_we_n === 1'b0) begin we1++; if (s1 && a_saddr != p1) ch1++; s1 = 1; p1 = a_saddr; end
        end
      end
      if (!d15) begin
        if (b_ready === 1'b1) d15 = 1;
        else begin
          lo15++;
          if (b_we_n === 1'b0) begin we15++; if (s15 && b_saddr != p15) ch15++; s15 = 1; p15 = b_saddr; end
        end
      end
    end
    @(posedge clk); #1; a_w = 1'b0; b_w = 1'b0;
    n_vec++; if (!d1 || lo1 != 2) begin n_err++; $display("FAIL lat_w1_low got=%0d exp=2", lo1); end
    n_vec++; if (we1 != 2 || ch1 != 1) begin n_err++; $display("FAIL lat_w1_we got=%0d/%0d exp=2/1", we1, ch1); end
    n_vec++; if (!d15 || lo15 != 30) begin n_err++; $display("FAIL lat_w15_low got=%0d exp=30", lo15); end
    n_vec++; if (we15 != 30 || ch15 != 1) begin n_err++; $display("FAIL lat_w15_we got=%0d/%0d exp=30/1", we15, ch15); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_both_en();
    test_reset_mid();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
